// File: rtl/serial_word_deserializer_pkg.sv
// Shared constants for the serial word deserializer.
// Holds the FSM state encoding and the bit-order constants.
// The bit-order values match the transmitting shift register's right_left input.
package serial_word_deserializer_pkg;

    // FSM state encoding
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RECV = 1'b1;

    // Bit-order selection, sampled from right_left at frame start
    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

    typedef enum logic {
        S_IDLE = ST_IDLE,
        S_RECV = ST_RECV
    } state_t;

endpackage

// File: rtl/serial_word_deserializer.sv
// Deserializer: collects WIDTH serial bits on en strobes into one parallel word.
// Latency: word_out/word_valid update on the edge that captures the last bit.
// Backpressure: none upstream; an unaccepted word is overwritten and flags a sticky overrun.
module serial_word_deserializer
    import serial_word_deserializer_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             start,
    input  logic             d_in,
    input  logic             right_left,
    input  logic             ack,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             busy,
    output logic [CNT_W-1:0] bit_count,
    output logic             overrun
);

    state_t           state;
    logic             dir;
    logic [WIDTH-1:0] shreg;

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] entry;
    logic             last_bit;
    logic             complete;

    // Next shift-register value for a data bit, and the first-bit load pattern
    always_comb begin
        shifted  = shreg;
        entry    = '0;
        if (dir == DIR_MSB_FIRST) begin
            shifted = {shreg[WIDTH-2:0], d_in};
        end else begin
            shifted = {d_in, shreg[WIDTH-1:1]};
        end
        if (right_left == DIR_MSB_FIRST) begin
            entry[0] = d_in;
        end else begin
            entry[WIDTH-1] = d_in;
        end
        last_bit = (bit_count == CNT_W'(WIDTH - 1));
        complete = (state == S_RECV) && en && !start && last_bit;
    end

    // Frame FSM, bit counter, shift register and output word/handshake state
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            dir        <= DIR_LSB_FIRST;
            shreg      <= '0;
            bit_count  <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // en without start is ignored while idle
                    if (en && start) begin
                        shreg     <= entry;
                        bit_count <= CNT_W'(1);
                        dir       <= right_left;
                        state     <= S_RECV;
                    end
                end
                S_RECV: begin
                    if (en) begin
                        if (start) begin
                            // A new start aborts the partial frame silently
                            shreg     <= entry;
                            bit_count <= CNT_W'(1);
                            dir       <= right_left;
                        end else if (last_bit) begin
                            shreg     <= shifted;
                            word_out  <= shifted;
                            bit_count <= '0;
                            state     <= S_IDLE;
                        end else begin
                            shreg     <= shifted;
                            bit_count <= bit_count + CNT_W'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase

            // A new word beats a same-cycle ack; ack only matters otherwise
            if (complete) begin
                word_valid <= 1'b1;
                if (word_valid && !ack) begin
                    overrun <= 1'b1;
                end
            end else if (ack) begin
                word_valid <= 1'b0;
            end
        end
    end

    assign busy = (state == S_RECV);

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Self-checking bench for serial_word_deserializer.
// Bit-list model checked every cycle plus directed literal expectations.
// Stimulus is fixed directed sequences; no DUT-dependent waits.
module tb_serial_word_deserializer;

    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          en = 1'b0;
    logic          start = 1'b0;
    logic          d_in = 1'b0;
    logic          right_left = 1'b0;
    logic          ack = 1'b0;
    logic [W-1:0]  word_out;
    logic          word_valid;
    logic          busy;
    logic [CW-1:0] bit_count;
    logic          overrun;

    int total = 0;
    int bad   = 0;

    serial_word_deserializer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clock      (clock),
        .reset      (reset),
        .en         (en),
        .start      (start),
        .d_in       (d_in),
        .right_left (right_left),
        .ack        (ack),
        .word_out   (word_out),
        .word_valid (word_valid),
        .busy       (busy),
        .bit_count  (bit_count),
        .overrun    (overrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic         chk_on = 1'b0;
    logic         m_busy;
    logic         m_dir;
    logic         m_bits[$];
    logic [W-1:0] m_word;
    logic         m_valid;
    logic         m_over;

    always @(posedge clock) begin
        logic         done;
        logic [W-1:0] w;
        done = 1'b0;
        w    = '0;
        if (reset) begin
            m_busy  = 1'b0;
            m_dir   = 1'b0;
            m_bits.delete();
            m_word  = '0;
            m_valid = 1'b0;
            m_over  = 1'b0;
            chk_on  = 1'b1;
        end else begin
            if (en && start) begin
                m_bits.delete();
                m_bits.push_back(d_in);
                m_dir  = right_left;
                m_busy = 1'b1;
            end else if (en && m_busy) begin
                m_bits.push_back(d_in);
                if (m_bits.size() == W) begin
                    // i-th received bit lands at W-1-i (MSB-first) or i (LSB-first)
                    for (int i = 0; i < W; i++) begin
                        if (m_dir) w[W-1-i] = m_bits[i];
                        else       w[i]     = m_bits[i];
                    end
                    m_bits.delete();
                    m_busy = 1'b0;
                    done   = 1'b1;
                end
            end
            if (done) begin
                if (m_valid && !ack) m_over = 1'b1;
                m_valid = 1'b1;
                m_word  = w;
            end else if (ack) begin
                m_valid = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clock) begin
        if (chk_on) begin
            check("word_out",   32'(word_out),   32'(m_word));
            check("word_valid", 32'(word_valid), 32'(m_valid));
            check("busy",       32'(busy),       32'(m_busy));
            check("bit_count",  32'(bit_count),  32'(m_bits.size()));
            check("overrun",    32'(overrun),    32'(m_over));
        end
    end

    int   rises = 0;
    logic prev_v = 1'b0;
    always @(negedge clock) begin
        if (word_valid === 1'b1 && prev_v !== 1'b1) rises = rises + 1;
        prev_v = word_valid;
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic s, input logic d, input logic rl, input logic a);
        en = 1'b1; start = s; d_in = d; right_left = rl; ack = a;
        @(posedge clock); #1;
        en = 1'b0; start = 1'b0; ack = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(posedge clock); #1;
        ack = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) begin
            @(posedge clock); #1;
        end
        reset = 1'b0;
    endtask

    int r0;

    initial begin
        // Reset with random activity on the inputs
        reset = 1'b1;
        repeat (2) begin
            en = 1'($urandom_range(0, 1)); start = 1'($urandom_range(0, 1));
            d_in = 1'($urandom_range(0, 1));
            @(posedge clock); #1;
        end
        reset = 1'b0; en = 1'b0; start = 1'b0;
        check("rst_word",  32'(word_out),   32'h0);
        check("rst_valid", 32'(word_valid), 32'h0);
        check("rst_busy",  32'(busy),       32'h0);
        check("rst_cnt",   32'(bit_count),  32'h0);
        check("rst_ovr",   32'(overrun),    32'h0);

        // Reset mid-frame discards the partial word
        send(1, 1, 1, 0);
        send(0, 1, 1, 0);
        check("mid_cnt", 32'(bit_count), 32'd2);
        check("mid_busy", 32'(busy), 32'd1);
        do_reset(1);
        check("midrst_busy",  32'(busy),       32'h0);
        check("midrst_cnt",   32'(bit_count),  32'h0);
        check("midrst_valid", 32'(word_valid), 32'h0);

        // MSB-first 1,0,1,0
        send(1, 1, 1, 0);
        send(0, 0, 1, 0);
        send(0, 1, 1, 0);
        check("msb_busy_pre", 32'(busy), 32'd1);
        send(0, 0, 1, 0);
        check("msb_word",  32'(word_out),   32'hA);
        check("msb_valid", 32'(word_valid), 32'd1);
        check("msb_busy",  32'(busy),       32'd0);
        do_ack();
        check("msb_ack", 32'(word_valid), 32'd0);

        // LSB-first 1,0,1,1 with 3-cycle gaps and right_left toggling
        send(1, 1, 0, 0);
        check("lsb_cnt1", 32'(bit_count), 32'd1);
        right_left = 1'b1; idle(3);
        check("lsb_gap1", 32'(bit_count), 32'd1);
        send(0, 0, 1, 0);
        check("lsb_cnt2", 32'(bit_count), 32'd2);
        right_left = 1'b0; idle(3);
        send(0, 1, 1, 0);
        check("lsb_cnt3", 32'(bit_count), 32'd3);
        idle(3);
        check("lsb_gap3", 32'(bit_count), 32'd3);
        send(0, 1, 1, 0);
        check("lsb_word", 32'(word_out), 32'hD);
        do_ack();

        // Restart mid-frame, MSB-first 0,0,0,1
        r0 = rises;
        send(1, 1, 1, 0);
        send(0, 1, 1, 0);
        send(1, 0, 1, 0);
        check("rst_restart_cnt", 32'(bit_count), 32'd1);
        send(0, 0, 1, 0);
        send(0, 0, 1, 0);
        send(0, 1, 1, 0);
        idle(1);
        check("restart_word",  32'(word_out),  32'h1);
        check("restart_rises", 32'(rises - r0), 32'd1);
        check("restart_ovr",   32'(overrun),   32'd0);
        do_ack();

        // Overrun: 1010 unaccepted, then 0110
        send(1, 1, 1, 0); send(0, 0, 1, 0); send(0, 1, 1, 0); send(0, 0, 1, 0);
        check("ovr_first_ovr", 32'(overrun), 32'd0);
        send(1, 0, 1, 0); send(0, 1, 1, 0); send(0, 1, 1, 0); send(0, 0, 1, 0);
        check("ovr_word",  32'(word_out),   32'h6);
        check("ovr_flag",  32'(overrun),    32'd1);
        check("ovr_valid", 32'(word_valid), 32'd1);
        do_ack();
        check("ovr_ack_valid", 32'(word_valid), 32'd0);
        check("ovr_sticky",    32'(overrun),    32'd1);
        send(1, 1, 1, 0); send(0, 1, 1, 0); send(0, 0, 1, 0); send(0, 0, 1, 1);
        check("third_word",  32'(word_out),   32'hC);
        check("third_valid", 32'(word_valid), 32'd1);
        check("third_ovr",   32'(overrun),    32'd1);

        // Ack in the completion cycle while a word is pending: no overrun
        do_reset(1);
        send(1, 0, 1, 0); send(0, 0, 1, 0); send(0, 1, 1, 0); send(0, 1, 1, 0);
        send(1, 0, 1, 0); send(0, 1, 1, 0); send(0, 0, 1, 0); send(0, 1, 1, 1);
        check("ackcmp_word",  32'(word_out),   32'h5);
        check("ackcmp_valid", 32'(word_valid), 32'd1);
        check("ackcmp_ovr",   32'(overrun),    32'd0);
        do_ack();

        // Back-to-back frames: 1001, then start on the very next cycle
        send(1, 1, 1, 0); send(0, 0, 1, 0); send(0, 0, 1, 0); send(0, 1, 1, 0);
        send(1, 1, 1, 0);
        check("b2b_cnt",  32'(bit_count), 32'd1);
        check("b2b_busy", 32'(busy),      32'd1);
        check("b2b_hold", 32'(word_out),  32'h9);
        send(0, 1, 1, 0); send(0, 1, 1, 0);
        check("b2b_hold2", 32'(word_out), 32'h9);
        send(0, 1, 1, 0);
        check("b2b_word", 32'(word_out), 32'hF);
        check("b2b_ovr",  32'(overrun),  32'd1);

        // LSB-first after MSB-first to exercise re-latching of order
        do_ack();
        send(1, 0, 0, 0); send(0, 1, 0, 0); send(0, 1, 0, 0); send(0, 0, 0, 0);
        check("lsb2_word", 32'(word_out), 32'h6);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
